// File: rtl/delay_line_ctrl.sv
// Controller for an external DEPTH-stage shift-register delay line: clears, primes,
// streams and drains the line. The FSM state is exported on dbg_state.
module delay_line_ctrl #(
  parameter int DEPTH = 20000,
  parameter int W     = 8,
  parameter int CW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [W-1:0]  s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [W-1:0]  m_data,
  input  logic          m_ready,
  input  logic          flush,
  output logic          sr_shift,
  output logic [W-1:0]  sr_din,
  input  logic [W-1:0]  sr_dout,
  output logic [CW-1:0] level,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshake: a word moves on a stream only in a cycle where valid and ready are
  // both high; valid never waits on ready, and ready/valid here are combinational
  // from state and the peer's signals so in and out can transfer in the same cycle.

  typedef enum logic [2:0] {
    ST_CLEAR      = 3'd0,
    ST_FILL       = 3'd1,
    ST_STREAM     = 3'd2,
    ST_DRAIN_SKIP = 3'd3,
    ST_DRAIN_OUT  = 3'd4
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C  = '0;

  state_t        state, state_n;
  logic [CW-1:0] level_q, level_n, level_acc;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      level_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      level_q <= level_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    level_n   = level_q;
    level_acc = level_q;
    cnt_n     = cnt;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = '0;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        // Reset parks the FSM here; the line must not shift while rst is held.
        sr_shift = !rst;
        if (cnt == LAST_C) begin
          cnt_n   = '0;
          state_n = ST_FILL;
        end else begin
          cnt_n = cnt + ONE_C;
        end
      end
      ST_FILL: begin
        s_ready   = 1'b1;
        sr_din    = s_data;
        sr_shift  = s_valid;
        level_acc = level_q + {{(CW-1){1'b0}}, s_valid};
        level_n   = level_acc;
        if (level_acc == DEPTH_C) state_n = ST_STREAM;
        if (flush && level_acc != ZERO_C) begin
          cnt_n   = DEPTH_C - level_acc;
          state_n = (cnt_n != ZERO_C) ? ST_DRAIN_SKIP : ST_DRAIN_OUT;
        end
      end
      ST_STREAM: begin
        s_ready  = m_ready;
        m_valid  = s_valid;
        sr_din   = s_data;
        sr_shift = s_valid & m_ready;
        if (flush) begin
          cnt_n   = DEPTH_C - level_acc;
          state_n = (cnt_n != ZERO_C) ? ST_DRAIN_SKIP : ST_DRAIN_OUT;
        end
      end
      ST_DRAIN_SKIP: begin
        busy     = 1'b1;
        sr_shift = 1'b1;
        cnt_n    = cnt - ONE_C;
        if (cnt == ONE_C) state_n = ST_DRAIN_OUT;
      end
      ST_DRAIN_OUT: begin
        busy     = 1'b1;
        m_valid  = 1'b1;
        sr_shift = m_ready;
        if (m_ready) begin
          level_n = level_q - ONE_C;
          if (level_q == ONE_C) state_n = ST_FILL;
        end
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  assign m_data    = sr_dout;
  assign level     = level_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl at DEPTH=4 with a behavioural model of the
// attached shift-register line.
module tb_delay_line_ctrl;
  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int CW    = 3;
  localparam logic [2:0] ST_CLEAR = 3'd0, ST_FILL = 3'd1, ST_STREAM = 3'd2,
                         ST_SKIP = 3'd3, ST_OUT = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, m_valid, m_ready, flush, sr_shift, busy;
  logic [W-1:0]  s_data, m_data, sr_din, sr_dout;
  logic [CW-1:0] level;
  logic [2:0]    dbg_state;
  logic [W-1:0]  line [DEPTH];
  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  exp_w;
  int            n_checks = 0;
  int            n_fail   = 0;

  // ---------------- clock / reset / line model ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (sr_shift) begin
      for (int i = DEPTH - 1; i > 0; i--) line[i] <= line[i-1];
      line[0] <= sr_din;
    end
  end
  assign sr_dout = line[DEPTH-1];

  delay_line_ctrl #(.DEPTH(DEPTH), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .sr_shift(sr_shift), .sr_din(sr_din), .sr_dout(sr_dout),
    .level(level), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h5A; m_ready = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b exp 0", m_valid); end
    n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL rst_sr_shift: got %b exp 0", sr_shift); end
    n_checks++; if (sr_din !== 8'h00) begin n_fail++; $display("FAIL rst_sr_din: got %h exp 00", sr_din); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d exp 0", level); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b exp 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (sr_shift !== 1'b1) begin n_fail++; $display("FAIL clear_shift[%0d]: got %b exp 1", i, sr_shift); end
      n_checks++; if (sr_din !== 8'h00) begin n_fail++; $display("FAIL clear_din[%0d]: got %h exp 00", i, sr_din); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy[%0d]: got %b exp 1", i, busy); end
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL clear_s_ready[%0d]: got %b exp 0", i, s_ready); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL post_clear_state: got %0d exp %0d", dbg_state, ST_FILL); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_clear_s_ready: got %b exp 1", s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_clear_busy: got %b exp 0", busy); end
    n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL post_clear_shift: got %b exp 0", sr_shift); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL post_clear_line: got %h exp 00", m_data); end
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [W-1:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = d[i]; m_ready = 1'b1;
      #1;
      n_checks++; if (level !== 3'(i)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d exp %0d", i, level, i); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fill_m_valid[%0d]: got %b exp 0", i, m_valid); end
      n_checks++; if (sr_shift !== 1'b1) begin n_fail++; $display("FAIL fill_shift[%0d]: got %b exp 1", i, sr_shift); end
      @(negedge clk);
    end
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d exp 4", level); end
    n_checks++; if (dbg_state !== ST_STREAM) begin n_fail++; $display("FAIL full_state: got %0d exp %0d", dbg_state, ST_STREAM); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL full_m_valid: got %b exp 0", m_valid); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stream_m_valid: got %b exp 1", m_valid); end
    n_checks++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL stream_m_data: got %h exp 11", m_data); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready: got %b exp 1", s_ready); end
    n_checks++; if (sr_shift !== 1'b1) begin n_fail++; $display("FAIL stream_shift: got %b exp 1", sr_shift); end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL stream_level: got %0d exp 4", level); end
    n_checks++; if (m_data !== 8'h22) begin n_fail++; $display("FAIL stream_next: got %h exp 22", m_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    s_valid = 1'b1; s_data = 8'h66; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready[%0d]: got %b exp 0", i, s_ready); end
      n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL bp_shift[%0d]: got %b exp 0", i, sr_shift); end
      n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_level[%0d]: got %0d exp 4", i, level); end
      n_checks++; if (m_data !== 8'h22) begin n_fail++; $display("FAIL bp_m_data[%0d]: got %h exp 22", i, m_data); end
      @(negedge clk);
    end
    m_ready = 1'b1;
    #1;
    n_checks++; if (sr_shift !== 1'b1) begin n_fail++; $display("FAIL bp_release_shift: got %b exp 1", sr_shift); end
    n_checks++; if (m_data !== 8'h22) begin n_fail++; $display("FAIL bp_release_data: got %h exp 22", m_data); end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    n_checks++; if (m_data !== 8'h33) begin n_fail++; $display("FAIL bp_after_data: got %h exp 33", m_data); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_after_level: got %0d exp 4", level); end
    @(negedge clk);
  endtask

  task automatic test_flush_stream();
    exp_q = '{8'h33, 8'h44, 8'h55, 8'h66};
    flush = 1'b1;
    #1;
    n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL fs_flush_shift: got %b exp 0", sr_shift); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (dbg_state !== ST_OUT) begin n_fail++; $display("FAIL fs_state: got %0d exp %0d", dbg_state, ST_OUT); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fs_busy: got %b exp 1", busy); end
    @(negedge clk);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      m_ready = c[0];
      #1;
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL fs_m_valid[%0d]: got %b exp 1", c, m_valid); end
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fs_s_ready[%0d]: got %b exp 0", c, s_ready); end
      exp_w = m_ready ? exp_q.pop_front() : exp_q[0];
      n_checks++; if (m_data !== exp_w) begin n_fail++; $display("FAIL fs_m_data[%0d]: got %h exp %h", c, m_data, exp_w); end
      @(negedge clk);
    end
    m_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fs_timeout: %0d words left exp 0", exp_q.size()); end
    #1;
    n_checks++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL fs_end_state: got %0d exp %0d", dbg_state, ST_FILL); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL fs_end_level: got %0d exp 0", level); end
    @(negedge clk);
  endtask

  task automatic test_flush_partial();
    s_valid = 1'b1; s_data = 8'hA1;
    @(negedge clk);
    s_data = 8'hA2;
    @(negedge clk);
    s_valid = 1'b0; flush = 1'b1;
    #1;
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL fp_level: got %0d exp 2", level); end
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (dbg_state !== ST_SKIP) begin n_fail++; $display("FAIL fp_skip_state[%0d]: got %0d exp %0d", i, dbg_state, ST_SKIP); end
      n_checks++; if (sr_shift !== 1'b1) begin n_fail++; $display("FAIL fp_skip_shift[%0d]: got %b exp 1", i, sr_shift); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fp_skip_m_valid[%0d]: got %b exp 0", i, m_valid); end
      @(negedge clk);
    end
    exp_q = '{8'hA1, 8'hA2};
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      m_ready = c[1];
      #1;
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL fp_m_valid[%0d]: got %b exp 1", c, m_valid); end
      exp_w = m_ready ? exp_q.pop_front() : exp_q[0];
      n_checks++; if (m_data !== exp_w) begin n_fail++; $display("FAIL fp_m_data[%0d]: got %h exp %h", c, m_data, exp_w); end
      @(negedge clk);
    end
    m_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fp_timeout: %0d words left exp 0", exp_q.size()); end
    #1;
    n_checks++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL fp_end_state: got %0d exp %0d", dbg_state, ST_FILL); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL fp_end_level: got %0d exp 0", level); end
    @(negedge clk);
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    #1;
    n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL fe_shift: got %b exp 0", sr_shift); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL fe_state: got %0d exp %0d", dbg_state, ST_FILL); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fe_busy: got %b exp 0", busy); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL fe_level: got %0d exp 0", level); end
    @(negedge clk);
  endtask

  task automatic test_flush_with_fill();
    logic [W-1:0] d [4];
    d = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = d[i]; flush = (i == 3);
      @(negedge clk);
    end
    s_valid = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (dbg_state !== ST_OUT) begin n_fail++; $display("FAIL ff_state: got %0d exp %0d", dbg_state, ST_OUT); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ff_level: got %0d exp 4", level); end
    @(negedge clk);
    exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      m_ready = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_checks++; if (m_data !== exp_w) begin n_fail++; $display("FAIL ff_m_data[%0d]: got %h exp %h", c, m_data, exp_w); end
      @(negedge clk);
    end
    m_ready = 1'b0;
    #1;
    n_checks++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL ff_end_state: got %0d exp %0d", dbg_state, ST_FILL); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] d [4];
    d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = d[i];
      @(negedge clk);
    end
    s_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; m_ready = 1'b1;
    #1;
    n_checks++; if (m_data !== 8'hC1) begin n_fail++; $display("FAIL rd_first: got %h exp c1", m_data); end
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL rd_level: got %0d exp 3", level); end
    rst = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rd_m_valid: got %b exp 0", m_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rd_rst_level: got %0d exp 0", level); end
    n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL rd_rst_shift: got %b exp 0", sr_shift); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (sr_shift !== 1'b1) begin n_fail++; $display("FAIL rd_clear_shift[%0d]: got %b exp 1", i, sr_shift); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL rd_end_state: got %0d exp %0d", dbg_state, ST_FILL); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rd_end_level: got %0d exp 0", level); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rd_line_cleared: got %h exp 00", m_data); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_backpressure();
    test_flush_stream();
    test_flush_partial();
    test_flush_empty();
    test_flush_with_fill();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
